// File: rtl/cpu_mem_pkg.sv
// Shared types and address helpers for the data-cache slice.
// Optional statistics counters in dcache_ctrl are enabled by defining DCACHE_STATS_EN.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } dcache_state_t;

    localparam int LINE_BYTES  = 8;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int CPU_ADDR_W  = 64;

    // Full-width tag and index fields; callers keep only the bits they need.
    typedef struct packed {
        logic [CPU_ADDR_W-1:0] tag;
        logic [CPU_ADDR_W-1:0] index;
    } addr_split_t;

    // Split a byte address into line index and tag for a cache of 2^idx_bits lines.
    function automatic addr_split_t split_addr(input logic [CPU_ADDR_W-1:0] addr,
                                               input int idx_bits);
        addr_split_t           s;
        logic [CPU_ADDR_W-1:0] line_num;
        line_num = addr >> OFFSET_BITS;
        s.index  = line_num & ((CPU_ADDR_W'(1) << idx_bits) - CPU_ADDR_W'(1));
        s.tag    = line_num >> idx_bits;
        return s;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped data cache.
// One combinational read port, one write port (fill writes tag+data+valid,
// update writes data only) and a synchronous clear of every valid bit.
module dcache_array
    import cpu_mem_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int TAG_W    = 57
) (
    input  logic                clk,
    input  logic                clr_all,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [63:0]         rd_data,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [63:0]         wr_data,
    input  logic                fill_en,
    input  logic                upd_en
);

    localparam int LINES = 1 << IDX_BITS;

    logic              valid_vec [LINES];
    logic [TAG_W-1:0]  tag_vec   [LINES];
    logic [63:0]       data_vec  [LINES];

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            logic             sel;
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [63:0]      data_reg;

            assign sel = (wr_idx == IDX_BITS'(gi));

            // Valid bit: clear-all wins over a fill on the same edge.
            always_ff @(posedge clk) begin
                if (clr_all) begin
                    valid_reg <= 1'b0;
                end else if (fill_en && sel) begin
                    valid_reg <= 1'b1;
                end
            end

            // Tag is written only on fill; data on fill or write-through update.
            always_ff @(posedge clk) begin
                if (fill_en && sel) begin
                    tag_reg <= wr_tag;
                end
                if ((fill_en || upd_en) && sel) begin
                    data_reg <= wr_data;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign tag_vec[gi]   = tag_reg;
            assign data_vec[gi]  = data_reg;
        end
    endgenerate

    assign rd_valid = valid_vec[rd_idx];
    assign rd_tag   = tag_vec[rd_idx];
    assign rd_data  = data_vec[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Loads hit in zero cycles; load misses and all stores stall the pipeline
// while a req/ack transaction to backing memory completes.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dcache_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic              inv_all,
    output logic [63:0]       rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - OFFSET_BITS - IDX_BITS;

    dcache_state_t state_reg, state_next;

    addr_split_t         split;
    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]    req_tag;

    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [63:0]         rd_data;
    logic                line_hit;

    logic                fill_en;
    logic                upd_en;
    logic                clr_all;
    logic                load_hit;
    logic                miss_start;

    // Address decomposition; the held request drives every lookup and the memory address.
    assign split   = split_addr(CPU_ADDR_W'(req_addr), IDX_BITS);
    assign req_idx = split.index[IDX_BITS-1:0];
    assign req_tag = split.tag[TAG_W-1:0];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{split.tag[CPU_ADDR_W-1:TAG_W],
                                split.index[CPU_ADDR_W-1:IDX_BITS],
                                req_addr[OFFSET_BITS-1:0]};

    assign line_hit = rd_valid && (rd_tag == req_tag);

    // Because the pipeline holds the request during a stall, address and
    // write data stay stable for the whole memory transaction.
    assign mem_addr  = {req_addr[ADDR_W-1:OFFSET_BITS], OFFSET_BITS'(0)};
    assign mem_wdata = req_wdata;

    // Invalidate is honoured only when idle; reset also wipes every line.
    assign clr_all = !reset || ((state_reg == IDLE) && inv_all);

    dcache_array #(
        .IDX_BITS (IDX_BITS),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk      (clk),
        .clr_all  (clr_all),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_data  ((state_reg == RD_MISS) ? mem_rdata : req_wdata),
        .fill_en  (fill_en),
        .upd_en   (upd_en)
    );

    // State register; reset abandons any outstanding memory transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, pipeline handshake and memory handshake; all outputs quiet while in reset.
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        rdata      = 64'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        fill_en    = 1'b0;
        upd_en     = 1'b0;
        load_hit   = 1'b0;
        miss_start = 1'b0;
        if (!reset) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        if (req_write) begin
                            stall      = 1'b1;
                            state_next = WR_THRU;
                        end else if (line_hit) begin
                            rdata    = rd_data;
                            load_hit = 1'b1;
                        end else begin
                            stall      = 1'b1;
                            miss_start = 1'b1;
                            state_next = RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    mem_req = 1'b1;
                    stall   = 1'b1;
                    if (mem_ack) begin
                        // Bypass the returning data straight to the pipeline.
                        stall      = 1'b0;
                        rdata      = mem_rdata;
                        fill_en    = 1'b1;
                        state_next = IDLE;
                    end
                end
                WR_THRU: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    stall   = 1'b1;
                    if (mem_ack) begin
                        // No allocate: only a resident line is refreshed.
                        stall      = 1'b0;
                        upd_en     = line_hit;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;

    // Saturating hit/miss counters; stores count toward neither.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_cnt_reg  <= 32'd0;
            miss_cnt_reg <= 32'd0;
        end else begin
            if (load_hit && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end
            if (miss_start && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`else
    logic unused_stats;
    assign unused_stats = load_hit ^ miss_start;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, hand-written
// invalidate/reset sequences and randomized traffic against a line-address model.
// Counter checks are compiled in when DCACHE_STATS_EN is defined.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        inv_all;
    logic [63:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_ctrl #(.IDX_BITS(4), .ADDR_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .inv_all   (inv_all),
        .rdata     (rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: backing memory by doubleword address, and the cache
    // as "which line address lives at each of the 16 slots".
    logic [63:0] mem_model [logic [63:0]];
    logic [63:0] ref_line  [int];
    logic [63:0] ref_data  [int];
    int          mdl_hits   = 0;
    int          mdl_misses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return (a / 8) * 8;
    endfunction

    function automatic logic [63:0] mem_read(input logic [63:0] line);
        if (mem_model.exists(line)) return mem_model[line];
        return {line[31:0] ^ 32'hA5A5_0F0F, ~line[31:0]};
    endfunction

    function automatic void model_clear();
        ref_line.delete();
        ref_data.delete();
    endfunction

    // Predict a request's outcome and update the cache model accordingly.
    function automatic void model_apply(input bit wr, input logic [63:0] addr,
                                        input logic [63:0] wd,
                                        output bit hit, output logic [63:0] data);
        logic [63:0] line;
        int          slot;
        line = line_of(addr);
        slot = int'((addr / 8) % 16);
        hit  = ref_line.exists(slot) && (ref_line[slot] == line);
        data = 64'd0;
        if (!wr) begin
            if (hit) begin
                data = ref_data[slot];
                mdl_hits++;
            end else begin
                data = mem_read(line);
                ref_line[slot] = line;
                ref_data[slot] = data;
                mdl_misses++;
            end
        end else if (hit) begin
            ref_data[slot] = wd;
        end
    endfunction

    // Drive one request (entered just after a posedge) and act as the slow
    // memory: ack on the lat-th cycle of mem_req. inv_mode 1 = inv_all with
    // the request, 2 = inv_all during the memory phase.
    task automatic access(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                          input int lat, input int inv_mode,
                          output logic [63:0] got, output int stall_cyc);
        int idle_st = 0;
        int cnt     = 0;
        bit done    = 0;
        int guard   = 0;
        got       = 64'd0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        inv_all   = (inv_mode == 1);
        mem_ack   = 1'b0;
        while (!done && guard < 100) begin
            guard++;
            @(negedge clk);
            if (!stall) begin
                got  = rdata;
                done = 1;
                chk("hit_no_memreq", 64'(mem_req), 64'd0);
            end else if (!mem_req) begin
                idle_st++;
            end else begin
                cnt++;
                if (inv_mode == 2) inv_all = 1'b1;
                chk("mem_we", 64'(mem_we), 64'(wr));
                chk("mem_addr", mem_addr, line_of(addr));
                if (wr) chk("mem_wdata", mem_wdata, wd);
                if (cnt == lat) begin
                    mem_ack = 1'b1;
                    if (wr) begin
                        mem_model[line_of(addr)] = wd;
                        mem_rdata = {$urandom, $urandom};
                    end else begin
                        mem_rdata = mem_read(line_of(addr));
                    end
                    #1;
                    chk("ack_stall", 64'(stall), 64'd0);
                    got  = rdata;
                    done = 1;
                end
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL access_timeout addr=%h actual=stuck expected=completion", addr);
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        req_valid = 1'b0;
        inv_all   = 1'b0;
        stall_cyc = idle_st + ((cnt > 0) ? cnt - 1 : 0);
    endtask

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          lat;
        int          exp_stall;
        bit          chk_rd;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t        vecs [9];
    logic [63:0] got;
    int          scyc;
    bit          hit;
    logic [63:0] exp_d;

    initial begin
        vecs[0] = '{0, 64'h40, 64'h0,    4, 4, 1, 64'hDEAD_BEEF};
        vecs[1] = '{0, 64'h40, 64'h0,    1, 0, 1, 64'hDEAD_BEEF};
        vecs[2] = '{1, 64'h40, 64'h1234, 2, 2, 0, 64'h0};
        vecs[3] = '{0, 64'h47, 64'h0,    1, 0, 1, 64'h1234};
        vecs[4] = '{1, 64'h80, 64'h5555, 3, 3, 0, 64'h0};
        vecs[5] = '{0, 64'h80, 64'h0,    2, 2, 1, 64'h5555};
        vecs[6] = '{0, 64'hC0, 64'h0,    2, 2, 1, 64'hC0C0_C0C0};
        vecs[7] = '{0, 64'h40, 64'h0,    3, 3, 1, 64'h1234};
        vecs[8] = '{0, 64'h40, 64'h0,    1, 0, 1, 64'h1234};
        mem_model[64'h40] = 64'hDEAD_BEEF;
        mem_model[64'hC0] = 64'hC0C0_C0C0;

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; inv_all = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_memreq", 64'(mem_req), 64'd0);
        chk("rst_memwe", 64'(mem_we), 64'd0);
`ifdef DCACHE_STATS_EN
        chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_stall", 64'(stall), 64'd0);
        chk("idle_rdata", rdata, 64'd0);
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata, hit, exp_d);
            access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat, 0, got, scyc);
            chk($sformatf("vec%0d_stall", i), 64'(scyc), 64'(vecs[i].exp_stall));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
        end
`ifdef DCACHE_STATS_EN
        chk("tbl_hit_cnt", 64'(hit_cnt), 64'(mdl_hits));
        chk("tbl_miss_cnt", 64'(miss_cnt), 64'(mdl_misses));
`endif

        // inv_all together with a load hit: the load still hits, then the line is gone.
        model_apply(0, 64'h40, 0, hit, exp_d);
        access(0, 64'h40, 0, 1, 1, got, scyc);
        model_clear();
        chk("inv_same_stall", 64'(scyc), 64'd0);
        chk("inv_same_rdata", got, 64'h1234);
        model_apply(0, 64'h40, 0, hit, exp_d);
        access(0, 64'h40, 0, 2, 0, got, scyc);
        chk("after_inv_stall", 64'(scyc), 64'd2);
        chk("after_inv_rdata", got, 64'h1234);

        // inv_all during RD_MISS is ignored: the fill survives.
        model_apply(0, 64'hC0, 0, hit, exp_d);
        access(0, 64'hC0, 0, 3, 2, got, scyc);
        chk("inv_miss_stall", 64'(scyc), 64'd3);
        model_apply(0, 64'hC0, 0, hit, exp_d);
        access(0, 64'hC0, 0, 1, 0, got, scyc);
        chk("inv_ign_stall", 64'(scyc), 64'd0);
        chk("inv_ign_rdata", got, 64'hC0C0_C0C0);

        // Reset in the middle of RD_MISS, then a stray ack.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h100;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_memreq", 64'(mem_req), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_memreq", 64'(mem_req), 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd0);
        chk("mid_rst_rdata", rdata, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        model_clear();
        mdl_hits = 0; mdl_misses = 0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        chk("stray_memreq", 64'(mem_req), 64'd0);
        chk("stray_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
        chk("post_rst_hit_cnt", 64'(hit_cnt), 64'd0);
        chk("post_rst_miss_cnt", 64'(miss_cnt), 64'd0);
`endif
        model_apply(0, 64'h100, 0, hit, exp_d);
        access(0, 64'h100, 0, 2, 0, got, scyc);
        chk("post_rst_stall", 64'(scyc), 64'd2);
        chk("post_rst_rdata", got, exp_d);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                bit do_inv;
                do_inv    = ($urandom_range(0, 1) == 1);
                req_valid = 1'b0;
                inv_all   = do_inv;
                @(negedge clk);
                chk("rnd_idle_stall", 64'(stall), 64'd0);
                chk("rnd_idle_rdata", rdata, 64'd0);
                chk("rnd_idle_memreq", 64'(mem_req), 64'd0);
                @(posedge clk); #1;
                inv_all = 1'b0;
                if (do_inv) model_clear();
            end else begin
                bit          wr;
                logic [63:0] addr;
                logic [63:0] wd;
                int          lat;
                wr   = ($urandom_range(0, 2) == 0);
                addr = 64'($urandom_range(0, 47)) * 8 + 64'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) addr = addr + (64'd1 << 40);
                wd   = {$urandom, $urandom};
                lat  = $urandom_range(1, 4);
                model_apply(wr, addr, wd, hit, exp_d);
                access(wr, addr, wd, lat, 0, got, scyc);
                chk($sformatf("rnd%0d_stall", i), 64'(scyc), (hit && !wr) ? 64'd0 : 64'(lat));
                if (!wr) chk($sformatf("rnd%0d_rdata", i), got, exp_d);
            end
        end
`ifdef DCACHE_STATS_EN
        chk("rnd_hit_cnt", 64'(hit_cnt), 64'(mdl_hits));
        chk("rnd_miss_cnt", 64'(miss_cnt), 64'(mdl_misses));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
